seq_divider64: RTL and testbench



---
 rtl/seq_divider64_pkg.sv | 13 +
 rtl/seq_divider64_if.sv | 23 ++
 rtl/seq_divider64_trial_sub.sv | 27 ++
 rtl/seq_divider64.sv | 88 ++++++++
 tb/tb_seq_divider64.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/seq_divider64_pkg.sv
// seq_divider64_pkg: shared state encoding and sizing helpers for the sequential divider
package seq_divider64_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;
    localparam int DIV_WIDTH_DEFAULT = 64;
    localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/seq_divider64_if.sv
// seq_divider64_if: start/done handshake with operand and result buses of the divider
interface seq_divider64_if
    import seq_divider64_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider64_trial_sub.sv
// trial_sub: (WIDTH+1)-bit minus zero-extended WIDTH-bit subtract, rippled through 4-bit slices
module trial_sub
    import seq_divider64_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);
    localparam int NS = WIDTH / 4;
    logic       w_bw;
    logic [4:0] w_s;
    always_comb begin
        w_bw   = 1'b0;
        w_s    = '0;
        o_diff = '0;
        for (int s = 0; s < NS; s++) begin
            w_s               = {1'b0, i_a[4*s +: 4]} - {1'b0, i_b[4*s +: 4]} - {4'd0, w_bw};
            o_diff[4*s +: 4]  = w_s[3:0];
            w_bw              = w_s[4];
        end
        // top bit of the difference; the subtrahend's top bit is zero
        o_borrow = i_a[WIDTH] ^ w_bw;
    end
endmodule

// File: rtl/seq_divider64.sv
// seq_divider64: unsigned restoring divider producing one quotient bit per clock
module seq_divider64
    import seq_divider64_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    seq_divider64_if.slave bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e       r_state, w_next;
    logic [WIDTH-1:0] r_r, r_q, r_div, r_quot, r_rem;
    logic [WIDTH-1:0] w_diff, w_r_next, w_q_next;
    logic [WIDTH:0]   w_t;
    logic [CW-1:0]    r_cnt;
    logic             r_dbz, w_borrow, w_accept, w_zero, w_busy, w_done;

    assign w_accept = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_zero   = bus.divisor == '0;
    assign w_t      = {r_r, r_q[WIDTH-1]};

    trial_sub #(.WIDTH(WIDTH)) u_sub (
        .i_a      (w_t),
        .i_b      (r_div),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // restore on borrow, otherwise keep the difference and shift in a 1
    assign w_r_next = w_borrow ? w_t[WIDTH-1:0] : w_diff;
    assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        if (r_state == RUN) w_next = (r_cnt == LAST) ? DONE : RUN;
        else                w_next = w_accept ? (w_zero ? DONE : RUN) : IDLE;
    end

    always_comb begin
        w_busy = r_state == RUN;
        w_done = r_state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r    <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_r   <= '0;
            r_q   <= bus.dividend;
            r_div <= bus.divisor;
            r_cnt <= '0;
            if (w_zero) begin
                r_quot <= '1;
                r_rem  <= bus.dividend;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_r   <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_quot <= w_q_next;
                r_rem  <= w_r_next;
                r_dbz  <= 1'b0;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider64.sv
// tb_seq_divider64: directed and random checks of seq_divider64 against plain a/b, a%b arithmetic
module tb_seq_divider64;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_divider64_if #(.WIDTH(W)) bus ();
    seq_divider64 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int           n_chk = 0;
    int           n_fail = 0;
    int           dn;
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;
    logic [W-1:0] ra, rb;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge where done is seen.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        int           cyc = 0;
        int           busy_n = 0;
        logic [W-1:0] eq, er;
        eq = (b == '0) ? '1 : a / b;
        er = (b == '0) ? a : a % b;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = {$urandom, $urandom};
        if (b != '0) begin
            check("hold_quotient", bus.quotient, prev_q);
            check("hold_remainder", bus.remainder, prev_r);
        end
        while (bus.done !== 1'b1 && cyc < 100) begin
            busy_n += (bus.busy === 1'b1) ? 1 : 0;
            bus.start = (cyc == inj - 1);
            if (bus.start) begin
                bus.dividend = 50;
                bus.divisor  = 5;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check("latency", W'(cyc), (b == '0) ? W'(0) : W'(W));
        check("busy_cycles", W'(busy_n), (b == '0) ? W'(0) : W'(W));
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("div_by_zero", W'(bus.div_by_zero), W'(b == '0));
        check("busy_at_done", W'(bus.busy), W'(0));
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("done_single_pulse", W'(bus.done), W'(0));
        check("busy_idle", W'(bus.busy), W'(0));
    endtask

    initial begin
        bus.start    = 1'b1;
        bus.dividend = 64'd100;
        bus.divisor  = 64'd7;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_quotient", bus.quotient, W'(0));
        check("rst_remainder", bus.remainder, W'(0));
        check("rst_dbz", W'(bus.div_by_zero), W'(0));
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", W'(bus.busy), W'(0));

        do_op(64'd100, 64'd7, 0);
        idle_check();
        do_op('1, 64'd1, 0);
        idle_check();
        do_op(64'd3, 64'd10, 0);
        idle_check();
        do_op(64'd5, 64'd0, 0);
        idle_check();

        do_op(64'd1000, 64'd3, 10);
        do_op(64'd50, 64'd5, 0);
        idle_check();

        // abort a run after 20 iterations
        bus.start    = 1'b1;
        bus.dividend = 64'd1 << 40;
        bus.divisor  = 64'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", W'(bus.busy), W'(0));
        check("abort_done", W'(bus.done), W'(0));
        check("abort_quotient", bus.quotient, W'(0));
        check("abort_remainder", bus.remainder, W'(0));
        check("abort_dbz", W'(bus.div_by_zero), W'(0));
        dn = 0;
        repeat (80) begin
            @(negedge clk);
            dn += (bus.done === 1'b1) ? 1 : 0;
        end
        check("abort_no_done", W'(dn), W'(0));
        prev_q = '0;
        prev_r = '0;
        do_op(64'd20, 64'd6, 0);
        idle_check();

        for (int i = 0; i < 600; i++) begin
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 63);
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 255));
                2:       rb = ra + W'($urandom_range(1, 1000));
                3:       rb = {32'd0, $urandom};
                default: rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            endcase
            do_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0);
            if ($urandom_range(0, 1) == 1) begin
                idle_check();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
